// File: rtl/oven_pkg.sv
// Shared types and constants for the oven front-panel blocks.
// to_bcd is evaluated at elaboration to build the reset and clamp digit vectors.
package oven_pkg;

  typedef enum logic [1:0] {IDLE, EDIT, CONVERT, CHECK} state_t;

  localparam int BTN_COMMIT = 0;
  localparam int BTN_NEXT   = 1;
  localparam int BTN_LOAD   = 2;

  localparam int BCD_MAX_DIGITS = 8;

  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value, input int num_digits);
    logic [4*BCD_MAX_DIGITS-1:0] bcd;
    int rem;
    bcd = '0;
    rem = value;
    for (int k = 0; k < BCD_MAX_DIGITS; k++) begin
      if (k < num_digits) begin
        bcd[4*k +: 4] = 4'(rem % 10);
        rem = rem / 10;
      end
    end
    return bcd;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector; the history clears to 0 so a button
// already held at reset release still counts as one edge.
module btn_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= '0;
    else       hist <= din;
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/setpoint_entry.sv
// Front-panel setpoint entry: edit BCD digits, convert MSD-first to binary,
// clamp to [MIN_VAL, MAX_VAL] and publish with a one-cycle valid strobe.
//
// state   | meaning
// IDLE    | panel off; digits, sel and value held
// EDIT    | load/next edges edit digits, commit starts conversion
// CONVERT | one digit per cycle, acc <- acc*10 + digit, MSD first
// CHECK   | clamp, publish value, pulse valid, back to EDIT
module setpoint_entry
  import oven_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int VAL_W       = 10,
  parameter int MIN_VAL     = 300,
  parameter int MAX_VAL     = 500,
  parameter int DEFAULT_VAL = 300
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          on_off,
  input  logic [2:0]                    btn,
  input  logic [3:0]                    sw,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [$clog2(NUM_DIGITS)-1:0] sel,
  output logic [VAL_W-1:0]              value,
  output logic                          valid,
  output logic                          busy,
  output logic                          clamped
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic [4*NUM_DIGITS-1:0] RST_DIGITS = (4*NUM_DIGITS)'(to_bcd(DEFAULT_VAL, NUM_DIGITS));
  localparam logic [4*NUM_DIGITS-1:0] MIN_DIGITS = (4*NUM_DIGITS)'(to_bcd(MIN_VAL, NUM_DIGITS));
  localparam logic [4*NUM_DIGITS-1:0] MAX_DIGITS = (4*NUM_DIGITS)'(to_bcd(MAX_VAL, NUM_DIGITS));
  localparam logic [VAL_W-1:0] MIN_V    = VAL_W'(MIN_VAL);
  localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
  localparam logic [VAL_W-1:0] DEF_V    = VAL_W'(DEFAULT_VAL);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  state_t           state;
  logic [VAL_W-1:0] acc;
  logic [VAL_W-1:0] acc_next;
  logic [SEL_W-1:0] cnt;
  logic [2:0]       rise;
  logic [3:0]       sw_sat;
  logic [3:0]       cur_digit;

  btn_edge #(.WIDTH(3)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .din   (btn),
    .rise  (rise)
  );

  assign sw_sat    = (sw > 4'd9) ? 4'd9 : sw;
  assign cur_digit = digits[4*cnt +: 4];
  // Intermediate sums never exceed the final value, so VAL_W bits suffice.
  assign acc_next  = (acc << 3) + (acc << 1) + VAL_W'(cur_digit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      digits  <= RST_DIGITS;
      sel     <= '0;
      value   <= DEF_V;
      valid   <= 1'b0;
      busy    <= 1'b0;
      clamped <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      valid <= 1'b0;
      if (!on_off) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= EDIT;
          EDIT: begin
            if (rise[BTN_COMMIT]) begin
              state <= CONVERT;
              busy  <= 1'b1;
              acc   <= '0;
              cnt   <= LAST_SEL;
            end else begin
              if (rise[BTN_LOAD]) digits[4*sel +: 4] <= sw_sat;
              if (rise[BTN_NEXT]) sel <= (sel == LAST_SEL) ? '0 : sel + 1'b1;
            end
          end
          CONVERT: begin
            acc <= acc_next;
            if (cnt == '0) state <= CHECK;
            else           cnt   <= cnt - 1'b1;
          end
          CHECK: begin
            if (acc < MIN_V) begin
              value   <= MIN_V;
              digits  <= MIN_DIGITS;
              clamped <= 1'b1;
            end else if (acc > MAX_V) begin
              value   <= MAX_V;
              digits  <= MAX_DIGITS;
              clamped <= 1'b1;
            end else begin
              value   <= acc;
              clamped <= 1'b0;
            end
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= EDIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_setpoint_entry.sv
// Bench for setpoint_entry: directed panel sequences plus random digit entry,
// checked against a decimal-arithmetic model of the panel.
module tb_setpoint_entry;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        on_off;
  logic [2:0]  btn;
  logic [3:0]  sw;
  logic [11:0] digits;
  logic [1:0]  sel;
  logic [9:0]  value;
  logic        valid, busy, clamped;

  logic        on_off2;
  logic [2:0]  btn2;
  logic [3:0]  sw2;
  logic [7:0]  digits2;
  logic [0:0]  sel2;
  logic [6:0]  value2;
  logic        valid2, busy2, clamped2;

  setpoint_entry dut (
    .clk(clk), .reset(reset), .on_off(on_off), .btn(btn), .sw(sw),
    .digits(digits), .sel(sel), .value(value), .valid(valid), .busy(busy), .clamped(clamped)
  );

  setpoint_entry #(.NUM_DIGITS(2), .VAL_W(7), .MIN_VAL(1), .MAX_VAL(60), .DEFAULT_VAL(30)) dut2 (
    .clk(clk), .reset(reset), .on_off(on_off2), .btn(btn2), .sw(sw2),
    .digits(digits2), .sel(sel2), .value(value2), .valid(valid2), .busy(busy2), .clamped(clamped2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Panel model: decimal digits (index 0 = least significant), cursor, published value.
  int md[3];
  int msel;
  int mval;
  int mclamp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_digits();
    logic [11:0] r;
    for (int k = 0; k < 3; k++) r[4*k +: 4] = 4'(md[k]);
    return r;
  endfunction

  task automatic model_reset();
    md[0] = 0; md[1] = 0; md[2] = 3;
    msel = 0; mval = 300; mclamp = 0;
  endtask

  task automatic press_ops(input bit ld, input bit nx, input int swv);
    btn = {ld, nx, 1'b0};
    sw  = 4'(swv);
    step();
    btn = '0;
    step();
    if (ld) md[msel] = (swv > 9) ? 9 : swv;
    if (nx) msel = (msel + 1) % 3;
  endtask

  task automatic set_digit(input int k, input int v);
    while (msel != k) press_ops(1'b0, 1'b1, 0);
    press_ops(1'b1, 1'b0, v);
  endtask

  task automatic commit_chk(input string tag, input bit with_load);
    int num, exp_v, exp_c;
    int busy_n, valid_n, valid_at;
    busy_n = 0; valid_n = 0; valid_at = 0;
    num = md[2] * 100 + md[1] * 10 + md[0];
    if (num < 300)      begin exp_v = 300; exp_c = 1; end
    else if (num > 500) begin exp_v = 500; exp_c = 1; end
    else                begin exp_v = num; exp_c = 0; end
    btn = {with_load, 1'b0, 1'b1};
    sw  = 4'($urandom_range(0, 15));
    for (int k = 1; k <= 10; k++) begin
      step();
      btn = '0;
      if (busy)  busy_n++;
      if (valid) begin valid_n++; valid_at = k; end
      if (k == 4) chk({tag, "/value_before_publish"}, 32'(value), 32'(mval));
    end
    mval = exp_v;
    mclamp = exp_c;
    if (exp_c != 0) begin
      md[0] = exp_v % 10; md[1] = (exp_v / 10) % 10; md[2] = exp_v / 100;
    end
    chk({tag, "/busy_cycles"}, 32'(busy_n), 32'd4);
    chk({tag, "/valid_count"}, 32'(valid_n), 32'd1);
    chk({tag, "/valid_latency"}, 32'(valid_at), 32'd5);
    chk({tag, "/value"}, 32'(value), 32'(mval));
    chk({tag, "/digits"}, 32'(digits), 32'(exp_digits()));
    chk({tag, "/clamped"}, 32'(clamped), 32'(mclamp));
    chk({tag, "/sel"}, 32'(sel), 32'(msel));
  endtask

  task automatic press2(input bit ld, input bit nx, input int swv);
    btn2 = {ld, nx, 1'b0};
    sw2  = 4'(swv);
    step();
    btn2 = '0;
    step();
  endtask

  initial begin
    int valid_n, valid_at, old_digits, n_ops, op;
    reset = 1'b1; on_off = 1'b0; btn = '0; sw = '0;
    on_off2 = 1'b0; btn2 = '0; sw2 = '0;
    model_reset();
    repeat (3) step();

    chk("reset/digits", 32'(digits), 32'h300);
    chk("reset/value", 32'(value), 32'd300);
    chk("reset/sel", 32'(sel), 32'd0);
    chk("reset/valid", 32'(valid), 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/clamped", 32'(clamped), 32'd0);
    chk("reset2/digits", 32'(digits2), 32'h30);
    chk("reset2/value", 32'(value2), 32'd30);

    reset = 1'b0;
    on_off = 1'b1;
    step();

    // 4,2,5 entered LSD first, in range
    press_ops(1'b1, 1'b0, 5);
    press_ops(1'b0, 1'b1, 0);
    press_ops(1'b1, 1'b0, 2);
    press_ops(1'b0, 1'b1, 0);
    press_ops(1'b1, 1'b0, 4);
    chk("entry/digits", 32'(digits), 32'h425);
    commit_chk("c425", 1'b0);

    set_digit(2, 7); set_digit(1, 9); set_digit(0, 9);
    commit_chk("c799", 1'b0);
    set_digit(2, 1); set_digit(1, 2); set_digit(0, 0);
    commit_chk("c120", 1'b0);

    // saturation, wrap, held button, simultaneous load+next
    set_digit(0, 12);
    chk("sat/digit0", 32'(digits[3:0]), 32'd9);
    chk("sat/digits", 32'(digits), 32'(exp_digits()));
    repeat (3) press_ops(1'b0, 1'b1, 0);
    chk("wrap/sel", 32'(sel), 32'd0);
    btn[1] = 1'b1;
    repeat (10) step();
    btn[1] = 1'b0;
    step();
    msel = (msel + 1) % 3;
    chk("hold/sel", 32'(sel), 32'd1);
    press_ops(1'b1, 1'b1, 6);
    chk("both/digits", 32'(digits), 32'(exp_digits()));
    chk("both/sel", 32'(sel), 32'd2);
    commit_chk("c_with_load", 1'b1);

    // abort two cycles into CONVERT
    valid_n = 0;
    old_digits = 32'(digits);
    btn[0] = 1'b1;
    step();
    btn[0] = 1'b0;
    step();
    on_off = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (valid) valid_n++;
    end
    chk("abort/valid", 32'(valid_n), 32'd0);
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/value", 32'(value), 32'(mval));
    btn[2] = 1'b1; sw = 4'd7;
    step();
    btn[2] = 1'b0;
    step();
    chk("abort/idle_ignores_load", 32'(digits), 32'(old_digits));
    on_off = 1'b1;
    step();
    press_ops(1'b1, 1'b0, 4);
    chk("resume/digits", 32'(digits), 32'(exp_digits()));

    // reset in the middle of a conversion
    btn[0] = 1'b1;
    step();
    btn[0] = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("midreset/digits", 32'(digits), 32'h300);
    chk("midreset/value", 32'(value), 32'd300);
    chk("midreset/busy", 32'(busy), 32'd0);
    chk("midreset/sel", 32'(sel), 32'd0);
    chk("midreset/clamped", 32'(clamped), 32'd0);
    reset = 1'b0;
    model_reset();
    step();

    for (int it = 0; it < 25; it++) begin
      n_ops = $urandom_range(1, 6);
      for (int j = 0; j < n_ops; j++) begin
        op = $urandom_range(0, 2);
        press_ops(op != 1, op != 0, $urandom_range(0, 15));
      end
      chk("rand/digits", 32'(digits), 32'(exp_digits()));
      chk("rand/sel", 32'(sel), 32'(msel));
      commit_chk("rand", 1'($urandom_range(0, 1)));
    end

    // two-digit instance: 9,9 clamps to 60
    on_off2 = 1'b1;
    step();
    press2(1'b1, 1'b0, 9);
    press2(1'b0, 1'b1, 0);
    press2(1'b1, 1'b0, 9);
    chk("d2/digits_entry", 32'(digits2), 32'h99);
    valid_n = 0; valid_at = 0;
    btn2[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      btn2 = '0;
      if (valid2) begin valid_n++; valid_at = k; end
    end
    chk("d2/valid_latency", 32'(valid_at), 32'd4);
    chk("d2/valid_count", 32'(valid_n), 32'd1);
    chk("d2/value", 32'(value2), 32'd60);
    chk("d2/digits", 32'(digits2), 32'h60);
    chk("d2/clamped", 32'(clamped2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
